// File: rtl/midi_rx_parser_if.sv
// Message bus from the MIDI IN front end to midi_ctrl.
// The receiver/parser drives it (master); midi_ctrl observes it (slave).
interface midi_rx_parser_if;
  logic       cmd_completed;
  logic       cmd_strobe;
  logic [7:0] status;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [1:0] bytes_cnt;
  logic       frame_err;

  modport master (
    output cmd_completed, cmd_strobe, status, data1, data2, bytes_cnt, frame_err
  );

  modport slave (
    input cmd_completed, cmd_strobe, status, data1, data2, bytes_cnt, frame_err
  );
endinterface

// File: rtl/midi_rx_parser.sv
// MIDI IN front end: 8N1 UART receiver (31250 baud at the default divider) feeding a
// MIDI message parser with running status. Holds the last complete message for midi_ctrl.
module midi_rx_parser #(
  parameter int unsigned BAUD_CNT_HALF = 1600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              midi_rx,
  midi_rx_parser_if.master  msg
);

  localparam int unsigned CntW = $clog2(2 * BAUD_CNT_HALF);
  localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_CNT_HALF - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(2 * BAUD_CNT_HALF - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} rx_state_e;
  typedef enum logic [1:0] {PsIdle, PsWait1, PsWait2, PsSysex} ps_state_e;

  // Synchronizer and edge-detect delay
  logic sync1_q, sync2_q, sync3_q;

  // Receiver state
  rx_state_e     rx_state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          frame_err_q;

  // Parser state and held message
  ps_state_e  ps_q;
  logic [7:0] cur_q;
  logic       need2_q;
  logic [7:0] d1_q;
  logic       completed_q;
  logic       strobe_q;
  logic [7:0] status_q;
  logic [7:0] data1_q;
  logic [7:0] data2_q;
  logic [1:0] bytes_cnt_q;

  logic       fall;
  logic       byte_valid;
  logic [7:0] rx_byte;

  assign fall       = sync3_q & ~sync2_q;
  // Good stop sample: the parser consumes the byte on this edge so the message
  // registers change one cycle after the stop sample.
  assign byte_valid = (rx_state_q == StStop) && (cnt_q == FullLast) && sync2_q;
  assign rx_byte    = shift_q;

  // Two-flop synchronizer plus one delay flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= midi_rx;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Receiver FSM: start-bit qualify at half bit, then sample mid-bit every full bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q  <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (rx_state_q)
        StIdle: begin
          if (fall) begin
            rx_state_q <= StStart;
            cnt_q      <= '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            // High at mid start bit is a glitch: silently back to idle
            rx_state_q <= sync2_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == FullLast) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              rx_state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == FullLast) begin
            cnt_q <= '0;
            if (sync2_q) begin
              rx_state_q <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              rx_state_q  <= StWaitHigh;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitHigh: begin
          if (sync2_q) rx_state_q <= StIdle;
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

  // Message parser: running status lives in PsWait1 with cur_q holding a channel status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q        <= PsIdle;
      cur_q       <= '0;
      need2_q     <= 1'b0;
      d1_q        <= '0;
      completed_q <= 1'b0;
      strobe_q    <= 1'b0;
      status_q    <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      bytes_cnt_q <= '0;
    end else begin
      strobe_q <= 1'b0;
      // Realtime bytes (F8..FF) are invisible to the parser
      if (byte_valid && (rx_byte < 8'hF8)) begin
        completed_q <= 1'b0;
        if (rx_byte[7]) begin
          cur_q <= rx_byte;
          if (rx_byte < 8'hF0) begin
            need2_q <= !((rx_byte[7:4] == 4'hC) || (rx_byte[7:4] == 4'hD));
            ps_q    <= PsWait1;
          end else begin
            case (rx_byte[3:0])
              4'h0: ps_q <= PsSysex;
              4'h1, 4'h3: begin
                need2_q <= 1'b0;
                ps_q    <= PsWait1;
              end
              4'h2: begin
                need2_q <= 1'b1;
                ps_q    <= PsWait1;
              end
              4'h6: begin
                status_q    <= rx_byte;
                data1_q     <= '0;
                data2_q     <= '0;
                bytes_cnt_q <= 2'd1;
                strobe_q    <= 1'b1;
                completed_q <= 1'b1;
                ps_q        <= PsIdle;
              end
              default: ps_q <= PsIdle;
            endcase
          end
        end else begin
          case (ps_q)
            PsWait1: begin
              if (need2_q) begin
                d1_q <= rx_byte;
                ps_q <= PsWait2;
              end else begin
                status_q    <= cur_q;
                data1_q     <= rx_byte;
                data2_q     <= '0;
                bytes_cnt_q <= 2'd2;
                strobe_q    <= 1'b1;
                completed_q <= 1'b1;
                // Channel messages keep running status; system common ones do not
                ps_q        <= (cur_q[7:4] != 4'hF) ? PsWait1 : PsIdle;
              end
            end
            PsWait2: begin
              status_q    <= cur_q;
              data1_q     <= d1_q;
              data2_q     <= rx_byte;
              bytes_cnt_q <= 2'd3;
              strobe_q    <= 1'b1;
              completed_q <= 1'b1;
              ps_q        <= (cur_q[7:4] != 4'hF) ? PsWait1 : PsIdle;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign msg.cmd_completed = completed_q;
  assign msg.cmd_strobe    = strobe_q;
  assign msg.status        = status_q;
  assign msg.data1         = data1_q;
  assign msg.data2         = data2_q;
  assign msg.bytes_cnt     = bytes_cnt_q;
  assign msg.frame_err     = frame_err_q;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Scoreboard bench for midi_rx_parser with BAUD_CNT_HALF=4 (8 clocks per bit).
module tb_midi_rx_parser;

  localparam int unsigned Half = 4;
  localparam int unsigned BitClks = 2 * Half;

  logic clk;
  logic rst;
  logic midi_rx;

  midi_rx_parser_if bus ();

  midi_rx_parser #(
    .BAUD_CNT_HALF (Half)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .midi_rx (midi_rx),
    .msg     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] n;
  } msg_t;

  msg_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_ferr = 0;
  int   ferr_seen = 0;

  // Reference model of the MIDI byte stream
  int         m_cur;        // current status awaiting data, -1 when none
  int         m_need;
  logic [7:0] m_buf[$];
  bit         m_completed;
  msg_t       m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur       = -1;
    m_need      = 0;
    m_buf.delete();
    m_completed = 1'b0;
    m_last      = '{8'h00, 8'h00, 8'h00, 2'd0};
  endtask

  task automatic model_emit(input msg_t m);
    exp_q.push_back(m);
    m_last      = m;
    m_completed = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    msg_t m;
    if (b >= 8'hF8) return;
    m_completed = 1'b0;
    if (b >= 8'h80) begin
      m_buf.delete();
      m_cur = -1;
      if (b <= 8'hEF) begin
        m_cur  = int'(b);
        m_need = (b[7:4] == 4'hC || b[7:4] == 4'hD) ? 1 : 2;
      end else if (b == 8'hF1 || b == 8'hF3) begin
        m_cur  = int'(b);
        m_need = 1;
      end else if (b == 8'hF2) begin
        m_cur  = int'(b);
        m_need = 2;
      end else if (b == 8'hF6) begin
        m = '{8'hF6, 8'h00, 8'h00, 2'd1};
        model_emit(m);
      end
      // F0 (SysEx), F4, F5, F7 leave no pending status: data is dropped
    end else begin
      if (m_cur < 0) return;
      m_buf.push_back(b);
      if (m_buf.size() == m_need) begin
        m.st = 8'(m_cur);
        m.d1 = m_buf[0];
        m.d2 = (m_need == 2) ? m_buf[1] : 8'h00;
        m.n  = 2'(m_need + 1);
        model_emit(m);
        m_buf.delete();
        if (m_cur >= 'hF0) m_cur = -1;
      end
    end
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_completed"}, 32'(bus.cmd_completed), 32'(m_completed));
    chk({tag, "_status"}, 32'(bus.status), 32'(m_last.st));
    chk({tag, "_data1"}, 32'(bus.data1), 32'(m_last.d1));
    chk({tag, "_data2"}, 32'(bus.data2), 32'(m_last.d2));
    chk({tag, "_bytes_cnt"}, 32'(bus.bytes_cnt), 32'(m_last.n));
  endtask

  // Expectations are queued before the frame goes out; the monitor consumes them
  task automatic send_byte(input logic [7:0] b, input bit good, input string tag);
    if (good) model_byte(b);
    else exp_ferr++;
    midi_rx = 1'b0;
    repeat (BitClks) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (BitClks) @(posedge clk);
    end
    midi_rx = good;
    repeat (BitClks) @(posedge clk);
    midi_rx = 1'b1;
    @(negedge clk);
    check_held(tag);
    if (!good) repeat (6) @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_completed"}, 32'(bus.cmd_completed), 32'h0);
    chk({tag, "_strobe"}, 32'(bus.cmd_strobe), 32'h0);
    chk({tag, "_status"}, 32'(bus.status), 32'h0);
    chk({tag, "_data1"}, 32'(bus.data1), 32'h0);
    chk({tag, "_data2"}, 32'(bus.data2), 32'h0);
    chk({tag, "_bytes_cnt"}, 32'(bus.bytes_cnt), 32'h0);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'h0);
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  msg_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.cmd_strobe) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got %0h %0h %0h %0d expected no message at %0t",
                   bus.status, bus.data1, bus.data2, bus.bytes_cnt, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_status", 32'(bus.status), 32'(mon_e.st));
          chk("strobe_data1", 32'(bus.data1), 32'(mon_e.d1));
          chk("strobe_data2", 32'(bus.data2), 32'(mon_e.d2));
          chk("strobe_bytes_cnt", 32'(bus.bytes_cnt), 32'(mon_e.n));
          chk("strobe_completed", 32'(bus.cmd_completed), 32'h1);
        end
      end
      if (bus.frame_err) begin
        ferr_seen++;
        chk("ferr_strobe_exclusive", 32'(bus.cmd_strobe), 32'h0);
      end
    end
  end

  logic [7:0] rb;
  int         r;

  initial begin
    model_reset();
    midi_rx = 1'b1;
    rst     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Three-byte control change
    send_byte(8'hB0, 1'b1, "cc_st");
    send_byte(8'h2E, 1'b1, "cc_d1");
    send_byte(8'h7F, 1'b1, "cc_d2");

    // Program change then running-status data byte
    send_byte(8'hC0, 1'b1, "pc_st");
    send_byte(8'h42, 1'b1, "pc_d1");
    send_byte(8'h43, 1'b1, "pc_rs");

    // Realtime byte inside a note-on
    send_byte(8'h90, 1'b1, "non_st");
    send_byte(8'h3C, 1'b1, "non_d1");
    send_byte(8'hF8, 1'b1, "non_rt");
    send_byte(8'h64, 1'b1, "non_d2");

    // SysEx swallows data; running status cleared afterwards
    send_byte(8'hF0, 1'b1, "sx_f0");
    send_byte(8'h01, 1'b1, "sx_01");
    send_byte(8'h02, 1'b1, "sx_02");
    send_byte(8'hF7, 1'b1, "sx_f7");
    send_byte(8'h05, 1'b1, "sx_05");

    // Framing error, then a clean message
    send_byte(8'h90, 1'b0, "ferr");
    send_byte(8'hB0, 1'b1, "aft_st");
    send_byte(8'h01, 1'b1, "aft_d1");
    send_byte(8'h02, 1'b1, "aft_d2");

    // Reset during data bit 4 of the second byte
    send_byte(8'hC0, 1'b1, "rstm_st");
    midi_rx = 1'b0;
    repeat (BitClks) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      midi_rx = 1'(8'h10 >> i);
      repeat (BitClks) @(posedge clk);
    end
    midi_rx = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (3) @(posedge clk);
    rst = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    send_byte(8'hC0, 1'b1, "post_st");
    send_byte(8'h10, 1'b1, "post_d1");

    // Single-cycle low glitch on the idle line
    @(posedge clk);
    midi_rx = 1'b0;
    @(posedge clk);
    midi_rx = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_held("glitch");

    // System common and tune request
    send_byte(8'hF2, 1'b1, "spp_st");
    send_byte(8'h11, 1'b1, "spp_d1");
    send_byte(8'h22, 1'b1, "spp_d2");
    send_byte(8'h33, 1'b1, "spp_drop");
    send_byte(8'hF6, 1'b1, "tune");

    // Randomized byte stream
    for (int k = 0; k < 160; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) rb = 8'($urandom_range(0, 8'h7F));
      else if (r < 60) rb = 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 68) rb = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 78) rb = 8'($urandom_range(8'hF0, 8'hF7));
      else rb = 8'($urandom_range(0, 8'h7F));
      send_byte(rb, (r % 23) != 0, "rnd");
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    chk("pending_msgs", 32'(exp_q.size()), 32'h0);
    chk("frame_err_count", 32'(ferr_seen), 32'(exp_ferr));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
